// File: rtl/uart_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared types and helpers for the configurable UART transmitter.
//   parity_t      : frame parity mode (NONE / EVEN / ODD)
//   tx_state_t    : serializer state encoding
//   baud_t        : run-time selectable baud rates
//   baud_divisor  : clock cycles per bit for a given clock and baud rate
//   decode_parity : maps the 2-bit parity select onto parity_t
// -----------------------------------------------------------------------------
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_t;

    function automatic int unsigned baud_rate(input baud_t baud);
        case (baud)
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Integer truncation: every bit lasts exactly this many clock cycles.
    function automatic int unsigned baud_divisor(input int unsigned clock_hz, input baud_t baud);
        return clock_hz / baud_rate(baud);
    endfunction

    // Encoding 3 is reserved and behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] sel);
        case (sel)
            2'd1:    return EVEN;
            2'd2:    return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO feeding the UART serializer. The head word is always
// presented on rdata (first-word fall-through) straight from the storage
// registers, so the serializer can consume it in the same cycle it pops.
// Ports:
//   clock  in   single clock, rising edge
//   reset  in   synchronous, active-high; empties the FIFO
//   push   in   write wdata this cycle (caller guarantees room or a pop)
//   pop    in   drop the head word this cycle (caller guarantees non-empty)
//   wdata  in   word to write
//   rdata  out  current head word, valid while count != 0
//   count  out  occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two; the
    // extra count bit distinguishes full from empty.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design samples the values from before the edge.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers and count is enough to make its contents unreachable.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // When full, a push and a pop target the same slot: the old head is
    // read here before the edge overwrites it, so ordering is preserved.
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_transmitter_configurable.sv
// -----------------------------------------------------------------------------
// uart_transmitter_configurable
// UART transmitter: a synchronous FIFO feeds a frame serializer with run-time
// selectable baud rate, parity and stop-bit count. Frame config is captured
// when a word is popped and held for the whole frame.
// Ports:
//   clock                  in   single clock, rising edge
//   reset                  in   synchronous, active-high; aborts any frame
//   write_enable           in   push data into the FIFO this cycle
//   data                   in   payload to push
//   buffer_full_threshold  in   almost-full level; 0 means FIFO_DEPTH
//   baudrate_select        in   0:9600 1:19200 2:57600 3:115200
//   parity_select          in   0:none 1:even 2:odd 3:none
//   stop_bits_select       in   0:one stop bit 1:two stop bits
//   buffer_full            out  fifo_count >= effective threshold
//   buffer_empty           out  fifo_count == 0
//   fifo_count             out  FIFO occupancy
//   overflow               out  1-cycle pulse after a dropped write
//   busy                   out  high while a frame is on the line
//   data_out               out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_transmitter_configurable
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 32,
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CW-1:0]         buffer_full_threshold,
    input  logic [1:0]            baudrate_select,
    input  logic [1:0]            parity_select,
    input  logic                  stop_bits_select,
    output logic                  buffer_full,
    output logic                  buffer_empty,
    output logic [CW-1:0]         fifo_count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  data_out
);

    localparam int unsigned DIV_9600   = baud_divisor(CLOCK_FREQ_HZ, BAUD_9600);
    localparam int unsigned DIV_19200  = baud_divisor(CLOCK_FREQ_HZ, BAUD_19200);
    localparam int unsigned DIV_57600  = baud_divisor(CLOCK_FREQ_HZ, BAUD_57600);
    localparam int unsigned DIV_115200 = baud_divisor(CLOCK_FREQ_HZ, BAUD_115200);
    // The slowest rate has the largest divisor; the counter only ever
    // reaches divisor-1, so it never wraps.
    localparam int BAUD_CW = (DIV_9600 > 2) ? $clog2(DIV_9600) : 1;
    localparam int BIT_CW  = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE   = TX_IDLE;
    localparam logic [2:0] S_START  = TX_START;
    localparam logic [2:0] S_DATA   = TX_DATA;
    localparam logic [2:0] S_PARITY = TX_PARITY;
    localparam logic [2:0] S_STOP   = TX_STOP;

    logic [2:0]            state;
    logic [BAUD_CW-1:0]    baud_cnt;
    logic [BAUD_CW-1:0]    frame_div_m1;
    logic [BAUD_CW-1:0]    sel_div_m1;
    logic [BIT_CW-1:0]     bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_acc;
    parity_t               frame_parity;
    logic                  frame_two_stop;
    logic                  baud_tick;
    logic                  last_stop;
    logic                  fifo_pop;
    logic                  push_accept;
    logic                  line_bit;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]         eff_threshold;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_accept),
        .pop   (fifo_pop),
        .wdata (data),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign buffer_empty  = (fifo_count == '0);
    assign eff_threshold = (buffer_full_threshold == '0) ? CW'(FIFO_DEPTH) : buffer_full_threshold;
    assign buffer_full   = (fifo_count >= eff_threshold);

    assign baud_tick = (baud_cnt == frame_div_m1);
    assign last_stop = (state == S_STOP) && baud_tick &&
                       (!frame_two_stop || (bit_cnt == BIT_CW'(1)));

    // Pop on the IDLE cycle, or on the last stop cycle so the next start
    // bit follows with no idle gap.
    assign fifo_pop    = ((state == S_IDLE) || last_stop) && !buffer_empty;
    // A full FIFO still accepts a write on the cycle its head is popped.
    assign push_accept = write_enable && ((fifo_count < CW'(FIFO_DEPTH)) || fifo_pop);

    always_comb begin
        // NOTE: defaults are assigned first so every path drives the
        // outputs and no latch is inferred.
        sel_div_m1 = BAUD_CW'(DIV_115200 - 1);
        case (baudrate_select)
            2'd0:    sel_div_m1 = BAUD_CW'(DIV_9600 - 1);
            2'd1:    sel_div_m1 = BAUD_CW'(DIV_19200 - 1);
            2'd2:    sel_div_m1 = BAUD_CW'(DIV_57600 - 1);
            default: sel_div_m1 = BAUD_CW'(DIV_115200 - 1);
        endcase
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            S_START:  line_bit = 1'b0;
            S_DATA:   line_bit = shift_reg[0];
            S_PARITY: line_bit = parity_acc;
            default:  line_bit = 1'b1;
        endcase
    end

    // data_out and busy are registered copies of the state's line level,
    // so the pad sees a glitch-free signal one cycle behind the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            parity_acc     <= 1'b0;
            frame_div_m1   <= '0;
            frame_parity   <= NONE;
            frame_two_stop <= 1'b0;
            data_out       <= 1'b1;
            busy           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            overflow <= write_enable && !push_accept;
            busy     <= (state != S_IDLE);
            data_out <= line_bit;

            if (fifo_pop) begin
                shift_reg      <= fifo_rdata;
                frame_div_m1   <= sel_div_m1;
                frame_parity   <= decode_parity(parity_select);
                frame_two_stop <= stop_bits_select;
                // Seeding with 1 for odd parity turns the running XOR into
                // the odd parity bit.
                parity_acc     <= (decode_parity(parity_select) == ODD);
                baud_cnt       <= '0;
                bit_cnt        <= '0;
                state          <= S_START;
            end else if (state != S_IDLE) begin
                if (!baud_tick) begin
                    baud_cnt <= baud_cnt + 1'b1;
                end else begin
                    baud_cnt <= '0;
                    case (state)
                        S_START: begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                        S_DATA: begin
                            parity_acc <= parity_acc ^ shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                            if (bit_cnt == BIT_CW'(DATA_WIDTH - 1)) begin
                                bit_cnt <= '0;
                                state   <= (frame_parity == NONE) ? S_STOP : S_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            bit_cnt <= '0;
                            state   <= S_STOP;
                        end
                        S_STOP: begin
                            // bit_cnt counts stop bits already sent.
                            if (last_stop) state <= S_IDLE;
                            else           bit_cnt <= bit_cnt + 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter_configurable.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter_configurable
// Bench for uart_transmitter_configurable at CLOCK_FREQ_HZ = 1_152_000
// (divisors 120/60/20/10). A behavioural model keeps the FIFO as a queue of
// words and the line as a queue of future per-cycle levels: a popped word is
// expanded into its whole frame (start, data LSB first, parity, stops), each
// bit repeated divisor times. The serializer may take a new word once at most
// the final stop cycle of the current frame is still pending.
// -----------------------------------------------------------------------------
module tb_uart_transmitter_configurable;

    localparam int DW     = 8;
    localparam int DEPTH  = 32;
    localparam int CLK_HZ = 1_152_000;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_enable = 1'b0;
    logic [DW-1:0] data = '0;
    logic [CW-1:0] thr = '0;
    logic [1:0]    baud_sel = 2'd3;
    logic [1:0]    par_sel = 2'd0;
    logic          stop_sel = 1'b0;

    logic          buffer_full;
    logic          buffer_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          busy;
    logic          data_out;

    uart_transmitter_configurable #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .CLOCK_FREQ_HZ (CLK_HZ)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .write_enable          (write_enable),
        .data                  (data),
        .buffer_full_threshold (thr),
        .baudrate_select       (baud_sel),
        .parity_select         (par_sel),
        .stop_bits_select      (stop_sel),
        .buffer_full           (buffer_full),
        .buffer_empty          (buffer_empty),
        .fifo_count            (fifo_count),
        .overflow              (overflow),
        .busy                  (busy),
        .data_out              (data_out)
    );

    always #5 clock = ~clock;

    // ---------------- model state ----------------
    logic [DW-1:0] m_q[$];
    bit            m_line[$];
    bit            m_dout = 1'b1;
    bit            m_busy = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_valid = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    endtask

    function automatic int bench_div(input logic [1:0] sel);
        case (sel)
            2'd0:    return CLK_HZ / 9600;
            2'd1:    return CLK_HZ / 19200;
            2'd2:    return CLK_HZ / 57600;
            default: return CLK_HZ / 115200;
        endcase
    endfunction

    task automatic model_step();
        logic [DW-1:0] w;
        bit            pop;
        bit            frame[$];
        int            div;
        if (reset) begin
            m_q.delete();
            m_line.delete();
            m_dout  = 1'b1;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        pop = (m_line.size() <= 1) && (m_q.size() > 0);
        w   = '0;
        if (pop) w = m_q.pop_front();
        if (m_line.size() > 0) begin
            m_dout = m_line.pop_front();
            m_busy = 1'b1;
        end else begin
            m_dout = 1'b1;
            m_busy = 1'b0;
        end
        if (pop) begin
            frame.push_back(1'b0);
            for (int i = 0; i < DW; i++) frame.push_back(w[i]);
            if (par_sel == 2'd1) frame.push_back(^w);
            if (par_sel == 2'd2) frame.push_back(~^w);
            frame.push_back(1'b1);
            if (stop_sel) frame.push_back(1'b1);
            div = bench_div(baud_sel);
            foreach (frame[i])
                for (int k = 0; k < div; k++) m_line.push_back(frame[i]);
        end
        m_ovf = write_enable && (m_q.size() >= DEPTH);
        if (write_enable && m_q.size() < DEPTH) m_q.push_back(data);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // One compare process: every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("data_out",     data_out,     m_dout);
                check("busy",         busy,         m_busy);
                check("overflow",     overflow,     m_ovf);
                check("fifo_count",   fifo_count,   m_q.size());
                check("buffer_empty", buffer_empty, m_q.size() == 0);
                check("buffer_full",  buffer_full,
                      m_q.size() >= ((thr == '0) ? DEPTH : int'(thr)));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        write_enable = 1'b1;
        data         = w;
        cyc();
        write_enable = 1'b0;
    endtask

    // Starts on the first cycle of a frame; samples each bit mid-period.
    task automatic capture_frame(input int div, output int len, output logic [15:0] bits);
        len  = 0;
        bits = '0;
        while (busy === 1'b1 && len < 20000) begin
            if ((len % div) == (div / 2) && (len / div) < 16) bits[len / div] = data_out;
            len++;
            cyc();
        end
        check("busy low after frame", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [DW-1:0] w, input int div, output int len, output logic [15:0] bits);
        push(w);
        cyc();
        cyc();
        capture_frame(div, len, bits);
    endtask

    task automatic wait_idle(input int bound);
        int g = 0;
        while ((busy !== 1'b0 || buffer_empty !== 1'b1) && g < bound) begin
            cyc();
            g++;
        end
        check("drained busy", busy, 1'b0);
        check("drained empty", buffer_empty, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int            len;
        logic [15:0]   bits;
        int            guard;

        // Reset values
        repeat (3) cyc();
        check("reset data_out", data_out, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset overflow", overflow, 1'b0);
        check("reset fifo_count", fifo_count, 0);
        check("reset buffer_empty", buffer_empty, 1'b1);
        check("reset buffer_full", buffer_full, 1'b0);
        reset = 1'b0;
        cyc();

        // 8N1 at 115200: latency and bit pattern of 0xA5
        baud_sel = 2'd3; par_sel = 2'd0; stop_sel = 1'b0;
        push(8'hA5);
        check("latency edge N", data_out, 1'b1);
        cyc();
        check("latency edge N+1", data_out, 1'b1);
        cyc();
        check("latency edge N+2", data_out, 1'b0);
        capture_frame(10, len, bits);
        check("8N1 frame length", len, 100);
        check("8N1 bit pattern", bits[9:0], 10'h34A);

        // Even then odd parity, two stop bits at 57600
        baud_sel = 2'd2; par_sel = 2'd1; stop_sel = 1'b1;
        run_frame(8'hA5, 20, len, bits);
        check("8E2 frame length", len, 240);
        check("8E2 parity bit", bits[9], 1'b0);
        check("8E2 stop bits", bits[11:10], 2'b11);
        par_sel = 2'd2;
        run_frame(8'hA5, 20, len, bits);
        check("8O2 frame length", len, 240);
        check("8O2 parity bit", bits[9], 1'b1);

        // Threshold, fill, overflow, write-on-pop (serializer blocked by a slow frame)
        baud_sel = 2'd0; par_sel = 2'd1; stop_sel = 1'b1; thr = CW'(4);
        push(8'h11);
        cyc();
        cyc();
        for (int i = 1; i <= 3; i++) push(DW'(i));
        check("count 3", fifo_count, 3);
        check("full at 3 thr 4", buffer_full, 1'b0);
        push(8'h04);
        check("full at 4 thr 4", buffer_full, 1'b1);
        thr = '0;
        #1;
        check("full at 4 thr 0", buffer_full, 1'b0);
        for (int i = 5; i <= 32; i++) push(DW'(8'h40 + i));
        check("count 32", fifo_count, 32);
        check("full at 32 thr 0", buffer_full, 1'b1);
        baud_sel = 2'd3; par_sel = 2'd0; stop_sel = 1'b0;
        push(8'h3C);
        check("overflow pulse", overflow, 1'b1);
        check("count after drop", fifo_count, 32);
        cyc();
        check("overflow one cycle", overflow, 1'b0);
        guard = 0;
        while (m_line.size() != 1 && guard < 3000) begin
            cyc();
            guard++;
        end
        push(8'h77);
        check("write on pop overflow", overflow, 1'b0);
        check("write on pop count", fifo_count, 32);
        wait_idle(8000);

        // Reset mid-DATA, then a clean frame
        push(8'hC3);
        push(8'h81);
        repeat (40) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid-frame reset data_out", data_out, 1'b1);
        check("mid-frame reset count", fifo_count, 0);
        check("mid-frame reset busy", busy, 1'b0);
        push(8'h96);
        check("post-reset edge N", data_out, 1'b1);
        cyc();
        check("post-reset edge N+1", data_out, 1'b1);
        cyc();
        check("post-reset edge N+2", data_out, 1'b0);
        wait_idle(400);

        // Config change mid-frame: first frame 8N1/115200, second 8O2/19200
        baud_sel = 2'd3; par_sel = 2'd0; stop_sel = 1'b0;
        push(8'hF0);
        push(8'h0F);
        baud_sel = 2'd1; par_sel = 2'd2; stop_sel = 1'b1;
        cyc();
        capture_frame(10, len, bits);
        check("back-to-back length", len, 820);
        check("first frame unaffected", bits[9:0], 10'h3E0);

        // Randomized traffic with random config and threshold changes
        for (int c = 0; c < 6000; c++) begin
            write_enable = ($urandom_range(0, 11) == 0);
            data         = DW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                baud_sel = 2'($urandom_range(1, 3));
                par_sel  = 2'($urandom);
                stop_sel = 1'($urandom);
                thr      = CW'($urandom_range(0, 33));
            end
            cyc();
        end
        write_enable = 1'b0;
        baud_sel = 2'd3;
        wait_idle(10000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
